ps2_key_tracker: RTL and testbench
==================================

# ps2_key_tracker

Parametrised PS/2 keyboard receiver and key-state tracker for the home-simulation front end. It synchronises the raw PS/2 clock/data lines, deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop), and interprets E0/F0 prefixes. It maintains a held/released flag for each of NUM_KEYS programmable scan codes. It replaces the fixed per-letter combinational comparators with one sequential block that tracks make/break state, checks frames and recovers from errors.

## Interface
- NUM_KEYS, 4: number of tracked keys, 1..16.
- KEY_CODES, {8'h1B, 8'h1C, 8'h23, 8'h4B}: packed 8*NUM_KEYS set-2 make codes; entry i is bits [8i+7:8i]. The default maps index 0=L, 1=D, 2=A, 3=S.
- TIMEOUT_CYCLES, 50000: number of idle clocks inside a frame before abort (1 ms at 50 MHz); minimum 16.
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_dat  in  1  raw PS/2 data pin, asynchronous.
- key_down  out  NUM_KEYS  level; bit i=1 while key i is held.
- key_press  out  NUM_KEYS  one-cycle pulse on the up->down transition of key i.
- key_release  out  NUM_KEYS  one-cycle pulse on the down->up transition of key i.
- code_valid  out  1  one-cycle pulse; a complete scan code (prefixes consumed) is on code/is_break/is_ext.
- code  out  8  last scan code, held until the next code_valid.
- is_break  out  1  the last code was preceded by F0.
- is_ext  out  1  the last code was preceded by E0.
- frame_err  out  1  one-cycle pulse on a bad start, parity, stop, or timeout.

## Operation
- Synchroniser: two flops on each of ps2_clk and ps2_dat, plus one history flop on the synchronised clock. A falling edge is history=1 and sync=0.
- Receiver FSM, states IDLE, SHIFT, CHECK:
  - IDLE: on a falling edge, sample the start bit, set bit count to 1, and go to SHIFT.
  - SHIFT: sample data on each falling edge. After the 11th bit go to CHECK.
  - Timeout counter: reset on every edge. When it reaches TIMEOUT_CYCLES in SHIFT, go to IDLE and pulse frame_err.
  - CHECK, one cycle: the frame is good iff start=0, stop=1 and XOR(data, parity)=1. A good byte goes to the decoder; otherwise pulse frame_err. Always return to IDLE.
- Decoder FSM, states WAIT, EXT, BRK, EXT_BRK:
  - From WAIT: byte E0 -> EXT, byte F0 -> BRK, any other byte is emitted.
  - From EXT: F0 -> EXT_BRK, any other byte is emitted as extended.
  - From BRK or EXT_BRK: the next byte is emitted as break, with is_ext taken from the state.
  - After emitting, return to WAIT.
  - frame_err forces WAIT, discarding any pending prefix.
- Emit: pulse code_valid and load code, is_break and is_ext.
- Key match: only non-extended codes match. Every index i with KEY_CODES[i]==code updates, so duplicate entries track together.
  - Make: if key_down[i]=0, set it and pulse key_press[i]. If already down (typematic repeat), there is no change and no pulse.
  - Break: if key_down[i]=1, clear it and pulse key_release[i]. If already up, there is no pulse.
- Multiple keys may be held simultaneously. Unmatched codes affect only code_valid/code/flags.

## Timing
- Reset: all outputs 0 (code=8'h00), both FSMs in IDLE/WAIT, counters 0. Reset mid-frame discards the partial frame. Any leftover bits are rejected by the start-bit check or the timeout.
- Each bit is captured in the cycle its synchronised falling edge is detected.
- Output latency is fixed and data-independent: code_valid, frame_err, key_down, key_press and key_release all change at the 4th rising clock edge after the first edge that samples the 11th ps2_clk low.
- key_press/key_release pulse in the same cycle as code_valid. key_down changes in that same cycle.
- Prefix bytes (E0, F0) produce no code_valid.
- frame_err pulses in the same relative cycle as code_valid would have.
- code_valid and frame_err are never both high.
- PS/2 bit period (60-100 us) far exceeds the pipeline depth, so there is no overlap between frames.

## Test plan
- Send make 0x23: code_valid=1 for one cycle, code=8'h23, is_break=0, key_down=4'b0010, key_press=4'b0010 for one cycle.
- Send 0x23 three more times (typematic), then F0 23: no further key_press pulses; after F0 23, key_down=0, key_release=4'b0010 once, is_break=1.
- Hold L (4B) and S (1B), then break L: key_down goes 0001 -> 1001 -> 1000, and key_release=0001 pulses once.
- Send E0 F0 4B: code=4B, is_ext=1, is_break=1, key_down unchanged; a corrupted parity frame gives frame_err=1, no code_valid, and decoder in WAIT.
- Send F0, then a bad-stop frame, then 4B: frame_err once, then the 4B is treated as a make (the prefix was dropped), key_press[0]=1.
- Send 5 bits, then idle 50000 clocks: frame_err pulses once. Then send a valid 1C: key_down[2]=1. Assert reset mid-frame: all outputs are 0 the next cycle.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with E0/F0 prefix decoding and per-key held/released tracking.
// Raw pins are synchronised, 11-bit frames are checked, and matched scan codes drive make/break state.
module ps2_key_tracker #(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = {8'h1B, 8'h1C, 8'h23, 8'h4B},
    parameter int                    TIMEOUT_CYCLES = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ps2_clk,
    input  logic                ps2_dat,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                code_valid,
    output logic [7:0]          code,
    output logic                is_break,
    output logic                is_ext,
    output logic                frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_t;
    typedef enum logic [1:0] {WAIT, EXT, BRK, EXT_BRK} dec_state_t;

    logic          clk_meta;
    logic          clk_sync;
    logic          clk_hist;
    logic          dat_meta;
    logic          dat_sync;
    logic          fall;

    rx_state_t     rx_state;
    rx_state_t     rx_next;
    logic [3:0]    bit_cnt;
    logic [10:0]   frame;
    logic [TW-1:0] timer;
    logic          timeout;
    logic          frame_good;
    logic [7:0]    rx_byte;
    logic          rx_byte_valid;
    logic          rx_err;

    dec_state_t    dec_state;
    dec_state_t    dec_next;
    logic          emit;
    logic          emit_brk;
    logic          emit_ext;
    logic [NUM_KEYS-1:0] key_hit;

    // Synchronisers reset to the idle-high line level so no false edge follows reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_hist <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            clk_hist <= clk_sync;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

    assign fall = clk_hist & ~clk_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state  <= IDLE;
            dec_state <= WAIT;
        end else begin
            rx_state  <= rx_next;
            dec_state <= dec_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        timeout = 1'b0;
        case (rx_state)
            IDLE: begin
                if (fall) rx_next = SHIFT;
            end
            SHIFT: begin
                if (fall && bit_cnt == 4'd10) begin
                    rx_next = CHECK;
                end else if (!fall && timer == TW'(TIMEOUT_CYCLES)) begin
                    rx_next = IDLE;
                    timeout = 1'b1;
                end
            end
            CHECK: begin
                rx_next = IDLE;
            end
            default: begin
                rx_next = IDLE;
            end
        endcase
    end

    // Frame layout after 11 right shifts: [0] start, [8:1] data, [9] odd parity, [10] stop.
    assign frame_good = ~frame[0] & frame[10] & (^frame[9:1]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt       <= '0;
            frame         <= '0;
            timer         <= '0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            rx_err        <= 1'b0;
        end else begin
            if (fall && rx_state == IDLE) begin
                frame   <= {dat_sync, 10'b0};
                bit_cnt <= 4'd1;
            end else if (fall && rx_state == SHIFT) begin
                frame   <= {dat_sync, frame[10:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (fall || rx_state != SHIFT) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            rx_byte_valid <= (rx_state == CHECK) && frame_good;
            rx_err        <= ((rx_state == CHECK) && !frame_good) || timeout;
            if (rx_state == CHECK) begin
                rx_byte <= frame[8:1];
            end
        end
    end

    always_comb begin
        dec_next = dec_state;
        emit     = 1'b0;
        emit_brk = 1'b0;
        emit_ext = 1'b0;
        if (rx_err) begin
            dec_next = WAIT;
        end else if (rx_byte_valid) begin
            case (dec_state)
                WAIT: begin
                    if (rx_byte == 8'hE0) begin
                        dec_next = EXT;
                    end else if (rx_byte == 8'hF0) begin
                        dec_next = BRK;
                    end else begin
                        emit = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_byte == 8'hF0) begin
                        dec_next = EXT_BRK;
                    end else begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        dec_next = WAIT;
                    end
                end
                BRK: begin
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                    dec_next = WAIT;
                end
                EXT_BRK: begin
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                    emit_ext = 1'b1;
                    dec_next = WAIT;
                end
                default: begin
                    dec_next = WAIT;
                end
            endcase
        end
    end

    // Extended codes never match, so E0-prefixed keys cannot alias the tracked set.
    always_comb begin
        key_hit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_hit[i] = emit && !emit_ext && (rx_byte == KEY_CODES[8*i +: 8]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_down    <= '0;
            key_press   <= '0;
            key_release <= '0;
            code_valid  <= 1'b0;
            code        <= '0;
            is_break    <= 1'b0;
            is_ext      <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            code_valid  <= emit;
            frame_err   <= rx_err;
            key_press   <= key_hit & ~key_down & {NUM_KEYS{~emit_brk}};
            key_release <= key_hit & key_down & {NUM_KEYS{emit_brk}};
            key_down    <= emit_brk ? (key_down & ~key_hit) : (key_down | key_hit);
            if (emit) begin
                code     <= rx_byte;
                is_break <= emit_brk;
                is_ext   <= emit_ext;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: frames are bit-banged onto the PS/2 pins,
// expected events are queued at stimulus time and matched against observed output events.
module tb_ps2_key_tracker;

    localparam int HALF = 8;

    typedef struct packed {
        logic        code_valid;
        logic        frame_err;
        logic [7:0]  code;
        logic        is_break;
        logic        is_ext;
        logic [3:0]  key_down;
        logic [3:0]  key_press;
        logic [3:0]  key_release;
        logic [31:0] cyc;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [3:0] key_down;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic       code_valid;
    logic [7:0] code;
    logic       is_break;
    logic       is_ext;
    logic       frame_err;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t mon_ev;
    ev_t e;
    ev_t o;
    int  checks = 0;
    int  failures = 0;
    int  cycle_cnt = 0;
    int  last_fall = 0;

    logic [3:0] m_down = 4'b0000;
    logic [7:0] m_code = 8'h00;
    logic       m_brk = 1'b0;
    logic       m_ext = 1'b0;
    logic [7:0] keys [4] = '{8'h4B, 8'h23, 8'h1C, 8'h1B};

    ps2_key_tracker #(
        .NUM_KEYS(4),
        .KEY_CODES({8'h1B, 8'h1C, 8'h23, 8'h4B}),
        .TIMEOUT_CYCLES(50000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .key_down(key_down),
        .key_press(key_press),
        .key_release(key_release),
        .code_valid(code_valid),
        .code(code),
        .is_break(is_break),
        .is_ext(is_ext),
        .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    // Any cycle carrying a pulse is recorded, so a stretched pulse shows up as an extra event.
    always @(negedge clock) begin
        if (!reset && (code_valid || frame_err || key_press != 4'b0 || key_release != 4'b0)) begin
            mon_ev.code_valid  = code_valid;
            mon_ev.frame_err   = frame_err;
            mon_ev.code        = code;
            mon_ev.is_break    = is_break;
            mon_ev.is_ext      = is_ext;
            mon_ev.key_down    = key_down;
            mon_ev.key_press   = key_press;
            mon_ev.key_release = key_release;
            mon_ev.cyc         = cycle_cnt;
            obs_q.push_back(mon_ev);
        end
    end

    function automatic ev_t model_code(input logic [7:0] b, input logic brk, input logic ext);
        ev_t r;
        r = '0;
        r.code_valid = 1'b1;
        r.code       = b;
        r.is_break   = brk;
        r.is_ext     = ext;
        for (int i = 0; i < 4; i++) begin
            if (!ext && keys[i] == b) begin
                if (!brk && !m_down[i]) begin
                    m_down[i]      = 1'b1;
                    r.key_press[i] = 1'b1;
                end else if (brk && m_down[i]) begin
                    m_down[i]        = 1'b0;
                    r.key_release[i] = 1'b1;
                end
            end
        end
        r.key_down = m_down;
        m_code = b;
        m_brk  = brk;
        m_ext  = ext;
        return r;
    endfunction

    function automatic ev_t model_err();
        ev_t r;
        r = '0;
        r.frame_err = 1'b1;
        r.code      = m_code;
        r.is_break  = m_brk;
        r.is_ext    = m_ext;
        r.key_down  = m_down;
        return r;
    endfunction

    // fault: 0 none, 1 bad start, 2 bad parity, 3 bad stop. Output is due 5 cycles after the 11th low is driven.
    task automatic send_frame(input logic [7:0] b, input int fault, input bit push, input ev_t ex);
        logic [10:0] bits;
        bits = {1'b1, ~^b, b, 1'b0};
        if (fault == 1) bits[0] = 1'b1;
        if (fault == 2) bits[9] = ~bits[9];
        if (fault == 3) bits[10] = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            ps2_dat = bits[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            if (i == 10 && push) begin
                ex.cyc = cycle_cnt + 5;
                exp_q.push_back(ex);
            end
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        repeat (2 * HALF) @(negedge clock);
    endtask

    task automatic send_code(input logic [7:0] b, input logic brk, input logic ext);
        send_frame(b, 0, 1'b1, model_code(b, brk, ext));
    endtask

    task automatic send_prefix(input logic [7:0] b);
        send_frame(b, 0, 1'b0, '0);
    endtask

    task automatic send_bad(input logic [7:0] b, input int fault);
        send_frame(b, fault, 1'b1, model_err());
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({key_down, key_press, key_release, code_valid, code, is_break, is_ext, frame_err} !== 24'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {key_down, key_press, key_release, code_valid, code, is_break, is_ext, frame_err});
        end
        reset = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_make();
        send_code(8'h23, 1'b0, 1'b0);
        repeat (10) @(negedge clock);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL make_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL make_event: got %h required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (o.key_press !== 4'b0010 || o.code !== 8'h23 || key_down !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL make_literal: got press %b code %h down %b required 0010 23 0010",
                     o.key_press, o.code, key_down);
        end
    endtask

    task automatic test_typematic();
        for (int i = 0; i < 3; i++) send_code(8'h23, 1'b0, 1'b0);
        send_prefix(8'hF0);
        send_code(8'h23, 1'b1, 1'b0);
        repeat (10) @(negedge clock);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL typematic_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL typematic_event: got %h required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (key_down !== 4'b0000 || is_break !== 1'b1 || o.key_release !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL typematic_literal: got down %b brk %b rel %b required 0000 1 0010",
                     key_down, is_break, o.key_release);
        end
    endtask

    task automatic test_multi_hold();
        send_code(8'h4B, 1'b0, 1'b0);
        send_code(8'h1B, 1'b0, 1'b0);
        send_prefix(8'hF0);
        send_code(8'h4B, 1'b1, 1'b0);
        repeat (10) @(negedge clock);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL multi_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL multi_event: got %h required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (key_down !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL multi_down: got %b required 1000", key_down);
        end
    endtask

    // A parity error after E0 must drop the prefix, so the following 1C is a plain make.
    task automatic test_ext_and_parity();
        send_prefix(8'hE0);
        send_prefix(8'hF0);
        send_code(8'h4B, 1'b1, 1'b1);
        send_prefix(8'hE0);
        send_bad(8'h1C, 2);
        send_code(8'h1C, 1'b0, 1'b0);
        repeat (10) @(negedge clock);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL ext_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL ext_event: got %h required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (key_down !== 4'b1100 || is_ext !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ext_literal: got down %b ext %b required 1100 0", key_down, is_ext);
        end
    endtask

    task automatic test_prefix_drop();
        send_prefix(8'hF0);
        send_bad(8'h4B, 3);
        send_code(8'h4B, 1'b0, 1'b0);
        send_bad(8'h23, 1);
        send_prefix(8'hF0);
        send_code(8'h1C, 1'b1, 1'b0);
        repeat (10) @(negedge clock);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL drop_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL drop_event: got %h required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (key_down !== 4'b1001) begin
            failures++;
            $display("[TB] FAIL drop_down: got %b required 1001", key_down);
        end
    endtask

    task automatic test_timeout();
        logic [10:0] bits;
        bits = {1'b1, ~^8'h1C, 8'h1C, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            ps2_dat = bits[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            if (i == 4) begin
                last_fall = cycle_cnt;
                exp_q.push_back(model_err());
            end
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        for (int k = 0; k < 60000 && obs_q.size() == 0; k++) @(negedge clock);
        checks++;
        if (obs_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL timeout_wait: got no event within 60000 cycles required frame_err");
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (int'(o.cyc) - last_fall < 50001 || int'(o.cyc) - last_fall > 50010) begin
                failures++;
                $display("[TB] FAIL timeout_delay: got %0d cycles required 50001..50010",
                         int'(o.cyc) - last_fall);
            end
            o.cyc = '0;
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL timeout_event: got %h required %h", o, e);
            end
        end
        send_code(8'h1C, 1'b0, 1'b0);
        repeat (10) @(negedge clock);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL timeout_count: got %0d events required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("[TB] FAIL timeout_after_event: got %h required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (key_down[2] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_key: got %b required 1", key_down[2]);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            ps2_dat = i[0];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({key_down, key_press, key_release, code_valid, code, is_break, is_ext, frame_err} !== 24'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid_frame: got %h required 0",
                     {key_down, key_press, key_release, code_valid, code, is_break, is_ext, frame_err});
        end
        ps2_dat = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        obs_q.delete();
        repeat (40) @(negedge clock);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL reset_quiet: got %0d events required 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_typematic();
        test_multi_hold();
        test_ext_and_parity();
        test_prefix_drop();
        test_timeout();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
